// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants, types and helpers for the shared-ALU arbiter and the blocks around it.
// Holds the ALU opcodes, operand widths, FSM state encoding and the operand/result mapping.
package alu_share_arbiter_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam int W_NARROW = 4;
  localparam int W_MID    = 6;
  localparam int W_WIDE   = 8;
  localparam int W_RES    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]          sel;
    logic [W_NARROW-1:0] a4;
    logic [W_NARROW-1:0] b4;
    logic [W_MID-1:0]    a6;
    logic [W_MID-1:0]    b6;
    logic [W_WIDE-1:0]   a8;
    logic [W_WIDE-1:0]   b8;
    logic                cin;
  } alu_in_t;

  // Only the operand group the opcode uses is loaded; the rest stay at zero.
  function automatic alu_in_t map_operands(input logic [1:0] op,
                                           input logic [W_WIDE-1:0] a,
                                           input logic [W_WIDE-1:0] b,
                                           input logic cin);
    alu_in_t m;
    m     = '0;
    m.sel = op;
    case (op)
      ALU_ADD: begin
        m.a4  = a[W_NARROW-1:0];
        m.b4  = b[W_NARROW-1:0];
        m.cin = cin;
      end
      ALU_SUB: begin
        m.a8  = a;
        m.b8  = b;
        m.cin = cin;
      end
      ALU_MUL: begin
        m.a6 = a[W_MID-1:0];
        m.b6 = b[W_MID-1:0];
      end
      default: begin
        m.a4 = a[W_NARROW-1:0];
        m.b4 = b[W_NARROW-1:0];
      end
    endcase
    return m;
  endfunction

  // Returns {carry, result} with bits outside the opcode's natural width cleared.
  function automatic logic [W_RES:0] mask_result(input logic [1:0] op,
                                                 input logic [W_RES-1:0] res,
                                                 input logic co);
    logic [W_RES:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = {co, 8'b0, res[W_NARROW-1:0]};
      ALU_SUB: r = {co, 4'b0, res[W_WIDE-1:0]};
      ALU_MUL: r = {1'b0, res};
      default: r = {1'b0, 8'b0, res[W_NARROW-1:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: lowest valid index at or above ptr, else lowest overall.
// Reusable by any block that time-shares a resource among NUM_REQ requesters.
module alu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic hit_hi;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit_hi    = 1'b0;
    any_valid = |req_valid;
    // Descending scans so the last hit written is the lowest index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(ptr))) begin
        hit_hi    = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    if (!hit_hi) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any_valid && (grant_idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin front end for one shared combinational ALU: registers operands, captures the
// result one cycle later and returns it tagged with the owning requester id.
//
// state    | meaning
// ST_IDLE  | arbitrating; req_ready follows the round-robin grant
// ST_ISSUE | ALU inputs registered and stable, result captured at the next edge
// ST_RESP  | response held on rsp_* until rsp_ready
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [W_WIDE*NUM_REQ-1:0]  req_a,
  input  logic [W_WIDE*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic [1:0]                 alu_sel,
  output logic [W_NARROW-1:0]        A_4,
  output logic [W_NARROW-1:0]        B_4,
  output logic [W_MID-1:0]           A_6,
  output logic [W_MID-1:0]           B_6,
  output logic [W_WIDE-1:0]          A_8,
  output logic [W_WIDE-1:0]          B_8,
  output logic                       carry_in,
  input  logic [W_RES-1:0]           result,
  input  logic                       carry_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [W_RES-1:0]           rsp_result,
  output logic                       rsp_carry,
  output logic                       busy,
  output logic [CNT_W-1:0]           ops_done
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt, id_q, grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                any_valid, accept;
  logic [1:0]          sel_op;
  logic [W_WIDE-1:0]   sel_a, sel_b;
  logic                sel_cin;
  alu_in_t             alu_q;
  logic [W_RES:0]      masked;

  alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[2*i +: 2];
        sel_a   = req_a[W_WIDE*i +: W_WIDE];
        sel_b   = req_b[W_WIDE*i +: W_WIDE];
        sel_cin = req_cin[i];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && any_valid && !rst;
  assign req_ready = accept ? grant : '0;
  assign ptr_nxt   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  assign masked    = mask_result(alu_q.sel, result, carry_out);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ALU registers only change on accept, so the ALU stays quiet between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      id_q       <= '0;
      alu_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        alu_q <= map_operands(sel_op, sel_a, sel_b, sel_cin);
        id_q  <= grant_idx;
        ptr   <= ptr_nxt;
      end
      if (state == ST_ISSUE) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_q;
        rsp_carry  <= masked[W_RES];
        rsp_result <= masked[W_RES-1:0];
      end
      if ((state == ST_RESP) && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 1'b1;
      end
    end
  end

  assign alu_sel  = alu_q.sel;
  assign A_4      = alu_q.a4;
  assign B_4      = alu_q.b4;
  assign A_6      = alu_q.a6;
  assign B_6      = alu_q.b6;
  assign A_8      = alu_q.a8;
  assign B_8      = alu_q.b8;
  assign carry_in = alu_q.cin;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU that puts junk in unused
// result bits so the response masking is exercised.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid, req_ready, req_cin;
  logic [2*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_a, req_b;
  logic [1:0]           alu_sel;
  logic [3:0]           A_4, B_4;
  logic [5:0]           A_6, B_6;
  logic [7:0]           A_8, B_8;
  logic                 carry_in, carry_out;
  logic [11:0]          result;
  logic                 rsp_valid, rsp_ready, rsp_carry, busy;
  logic [ID_W-1:0]      rsp_id;
  logic [11:0]          rsp_result;
  logic [CNT_W-1:0]     ops_done;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_sel(alu_sel), .A_4(A_4), .B_4(B_4), .A_6(A_6), .B_6(B_6),
    .A_8(A_8), .B_8(B_8), .carry_in(carry_in),
    .result(result), .carry_out(carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .busy(busy), .ops_done(ops_done)
  );

  logic [4:0] add_sum;
  logic [8:0] sub_diff;

  always_comb begin
    add_sum   = {1'b0, A_4} + {1'b0, B_4} + {4'b0, carry_in};
    sub_diff  = {1'b0, A_8} - {1'b0, B_8} - {8'b0, carry_in};
    result    = '0;
    carry_out = 1'b0;
    case (alu_sel)
      ALU_ADD: begin result = {8'h5A, add_sum[3:0]}; carry_out = add_sum[4]; end
      ALU_SUB: begin result = {4'h9, sub_diff[7:0]}; carry_out = sub_diff[8]; end
      ALU_MUL: begin result = {6'b0, A_6} * {6'b0, B_6}; carry_out = 1'b1; end
      default: begin result = {8'hC3, A_4 & B_4}; carry_out = 1'b1; end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ops = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
    req_op[2*r +: 2] = op;
    req_a[8*r +: 8]  = a;
    req_b[8*r +: 8]  = b;
    req_cin[r]       = cin;
  endtask

  // Expected {alu_sel, A_4, B_4, A_6, B_6, A_8, B_8, carry_in}.
  function automatic logic [63:0] exp_alu(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
    case (op)
      ALU_ADD: return {25'b0, op, a[3:0], b[3:0], 6'b0, 6'b0, 8'b0, 8'b0, cin};
      ALU_SUB: return {25'b0, op, 4'b0, 4'b0, 6'b0, 6'b0, a, b, cin};
      ALU_MUL: return {25'b0, op, 4'b0, 4'b0, a[5:0], b[5:0], 8'b0, 8'b0, 1'b0};
      default: return {25'b0, op, a[3:0], b[3:0], 6'b0, 6'b0, 8'b0, 8'b0, 1'b0};
    endcase
  endfunction

  // One full transaction from requester r; bp>0 stalls rsp_ready that many cycles
  // while the next requester in rotation is also asking.
  task automatic do_op(input string tag, input int r, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [11:0] exp_res, input logic exp_c, input int bp);
    int n;
    int other;
    other = (r + 1) % NUM_REQ;
    set_req(r, op, a, b, cin);
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin
      tick();
      n++;
    end
    chk_eq({tag, " grant"}, 64'(req_ready), 64'(1 << r));
    tick();
    req_valid[r] = 1'b0;
    chk_eq({tag, " alu regs"}, {25'b0, alu_sel, A_4, B_4, A_6, B_6, A_8, B_8, carry_in},
           exp_alu(op, a, b, cin));
    chk_eq({tag, " issue state"}, {61'b0, rsp_valid, busy, |req_ready}, 64'b010);
    tick();
    chk_eq({tag, " rsp"}, {47'b0, rsp_valid, 2'b0, rsp_id, rsp_result, rsp_carry},
           {47'b0, 1'b1, 2'b0, ID_W'(r), exp_res, exp_c});
    if (bp > 0) begin
      set_req(other, ALU_ADD, 8'h01, 8'h01, 1'b0);
      req_valid[other] = 1'b1;
    end
    for (int k = 0; k < bp; k++) begin
      tick();
      chk_eq({tag, " stall"}, {45'b0, rsp_valid, busy, |req_ready, rsp_id, rsp_result, rsp_carry},
             {45'b0, 1'b1, 1'b1, 1'b0, ID_W'(r), exp_res, exp_c});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    chk_eq({tag, " done"}, {46'b0, rsp_valid, busy, ops_done}, {46'b0, 1'b0, 1'b0, 16'(exp_ops)});
    if (bp > 0) begin
      chk_eq({tag, " next grant"}, 64'(req_ready), 64'(1 << other));
      req_valid = '0;
    end
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  int g, n, last;

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_cin = '0;
    tick();
    tick();
    req_valid = 4'b0001;
    #1;
    chk_eq("reset ready", 64'(req_ready), 64'd0);
    chk_eq("reset outs", {25'b0, alu_sel, A_4, B_4, A_6, B_6, A_8, B_8, carry_in}, 64'd0);
    chk_eq("reset rsp", {44'b0, rsp_valid, rsp_id, rsp_result, rsp_carry, busy, ops_done}, 64'd0);
    rst = 1'b0;
    req_valid = '0;
    tick();

    do_op("add0", 0, ALU_ADD, 8'd5,   8'd3,   1'b0, 12'h008, 1'b0, 0);
    do_op("add1", 0, ALU_ADD, 8'd15,  8'd1,   1'b1, 12'h001, 1'b1, 0);
    do_op("sub0", 2, ALU_SUB, 8'd100, 8'd25,  1'b0, 12'h04B, 1'b0, 0);
    do_op("sub1", 2, ALU_SUB, 8'd50,  8'd100, 1'b0, 12'h0CE, 1'b1, 0);
    do_op("mul",  1, ALU_MUL, 8'd63,  8'd63,  1'b1, 12'hF81, 1'b0, 0);
    do_op("and",  1, ALU_AND, 8'h0D,  8'h0A,  1'b1, 12'h008, 1'b0, 0);
    do_op("bp",   3, ALU_SUB, 8'd200, 8'd55,  1'b1, 12'h090, 1'b0, 10);

    // Round robin with every requester asking, starting from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 0;
    for (int r = 0; r < NUM_REQ; r++) set_req(r, ALU_ADD, 8'(r), 8'd1, 1'b0);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    g = 0; n = 0; last = 0;
    while (g < 5 && n < 60) begin
      chk_eq("rr onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (rsp_valid) chk_eq("rr rsp id", 64'(rsp_id), 64'(last));
      if (req_ready != '0) begin
        chk_eq("rr grant", 64'(req_ready), 64'(1 << order[g]));
        last = order[g];
        g++;
      end
      tick();
      n++;
    end
    req_valid = '0;
    chk_eq("rr grants seen", 64'(g), 64'd5);
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk_eq("rr idle", 64'(busy), 64'd0);
    chk_eq("rr ops_done", 64'(ops_done), 64'd5);
    rsp_ready = 1'b0;

    // Reset while the operation is in ISSUE.
    set_req(2, ALU_SUB, 8'd9, 8'd4, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk_eq("rst grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk_eq("rst in issue", 64'({rsp_valid, busy}), 64'b01);
    rst = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk_eq("rst cycle ready", 64'(req_ready), 64'd0);
    tick();
    chk_eq("rst after outs", {25'b0, alu_sel, A_4, B_4, A_6, B_6, A_8, B_8, carry_in}, 64'd0);
    chk_eq("rst after rsp", {44'b0, rsp_valid, rsp_id, rsp_result, rsp_carry, busy, ops_done}, 64'd0);
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_eq("rst no rsp", 64'({rsp_valid, busy}), 64'd0);
    end
    req_valid = 4'b1010;
    #1;
    chk_eq("rst first grant", 64'(req_ready), 64'b0010);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
